// File: rtl/irrigacao_pkg.sv
// Shared types and constants for the irrigation tank plant model:
// region enum, default rates/thresholds, sensor-fault selector codes.
package irrigacao_pkg;

  typedef enum logic [1:0] {
    VAZIO = 2'd0,
    BAIXO = 2'd1,
    MEDIO = 2'd2,
    ALTO  = 2'd3
  } regiao_t;

  localparam int DEF_LEVEL_W    = 8;
  localparam int DEF_TICK_DIV   = 4;
  localparam int DEF_FILL_RATE  = 3;
  localparam int DEF_GT_RATE    = 1;
  localparam int DEF_AS_RATE    = 2;
  localparam int DEF_B_TH       = 32;
  localparam int DEF_M_TH       = 128;
  localparam int DEF_A_TH       = 224;
  localparam int DEF_INIT_LEVEL = 0;

  localparam logic [1:0] FAULT_NONE = 2'd0;
  localparam logic [1:0] FAULT_B    = 2'd1;
  localparam logic [1:0] FAULT_M    = 2'd2;
  localparam logic [1:0] FAULT_A    = 2'd3;

  function automatic regiao_t regiao_de(input int unsigned lvl,
                                        input int unsigned b_th,
                                        input int unsigned m_th,
                                        input int unsigned a_th);
    regiao_t r;
    if (lvl >= a_th) begin
      r = ALTO;
    end else if (lvl >= m_th) begin
      r = MEDIO;
    end else if (lvl >= b_th) begin
      r = BAIXO;
    end else begin
      r = VAZIO;
    end
    return r;
  endfunction

  // Thermometer decode, bit order {A, M, B}
  function automatic logic [2:0] sensores_de(input regiao_t r);
    logic [2:0] s;
    case (r)
      VAZIO:   s = 3'b000;
      BAIXO:   s = 3'b001;
      MEDIO:   s = 3'b011;
      ALTO:    s = 3'b111;
      default: s = 3'b000;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/divisor_tick.sv
// Level-update prescaler: tick is high on the last count of each TICK_DIV-cycle period.
module divisor_tick #(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_last;

  assign w_last = (r_cnt == LAST);

  // Free-running counter wrapping at TICK_DIV-1
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign tick = w_last;

endmodule

// File: rtl/nivel_tanque_sim.sv
// Water-tank plant model: integrates VE/GT/AS into a level and drives A/M/B sensors.
// Optional SENSOR_FAULT_EN adds fault_sel/fault_val to force individual sensor outputs.
module nivel_tanque_sim
  import irrigacao_pkg::*;
#(
  parameter int LEVEL_W    = DEF_LEVEL_W,
  parameter int TICK_DIV   = DEF_TICK_DIV,
  parameter int FILL_RATE  = DEF_FILL_RATE,
  parameter int GT_RATE    = DEF_GT_RATE,
  parameter int AS_RATE    = DEF_AS_RATE,
  parameter int B_TH       = DEF_B_TH,
  parameter int M_TH       = DEF_M_TH,
  parameter int A_TH       = DEF_A_TH,
  parameter int INIT_LEVEL = DEF_INIT_LEVEL
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               VE,
  input  logic               GT,
  input  logic               AS,
`ifdef SENSOR_FAULT_EN
  input  logic [1:0]         fault_sel,
  input  logic               fault_val,
`endif
  output logic               A,
  output logic               M,
  output logic               B,
  output logic [LEVEL_W-1:0] level,
  output logic               overflow,
  output logic               dry
);

  // Two guard bits give room for both the sign and a carry past LEVEL_MAX
  localparam int SUM_W = LEVEL_W + 2;
  localparam logic signed [SUM_W-1:0] FILL_S = SUM_W'(FILL_RATE);
  localparam logic signed [SUM_W-1:0] GT_S   = SUM_W'(GT_RATE);
  localparam logic signed [SUM_W-1:0] AS_S   = SUM_W'(AS_RATE);
  localparam logic signed [SUM_W-1:0] ZERO_S = '0;
  localparam logic signed [SUM_W-1:0] MAX_S  = $signed({2'b00, {LEVEL_W{1'b1}}});

  logic                      w_tick;
  logic signed [SUM_W-1:0]   w_delta;
  logic signed [SUM_W-1:0]   w_sum;
  logic [LEVEL_W-1:0]        w_level_nxt;
  logic                      w_ovf_set;
  logic                      w_dry_set;
  logic [LEVEL_W-1:0]        r_level;
  logic                      r_overflow;
  logic                      r_dry;
  regiao_t                   r_regiao;
  regiao_t                   w_regiao_nxt;
  logic [2:0]                w_amb;
  logic [2:0]                w_amb_out;

  divisor_tick #(
    .TICK_DIV (TICK_DIV)
  ) u_divisor_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (w_tick)
  );

  assign w_delta = (VE ? FILL_S : ZERO_S) - (GT ? GT_S : ZERO_S) - (AS ? AS_S : ZERO_S);
  assign w_sum   = $signed({2'b00, r_level}) + w_delta;

  // Saturate the net update and flag which bound was hit
  always_comb begin
    w_level_nxt = r_level;
    w_ovf_set   = 1'b0;
    w_dry_set   = 1'b0;
    if (w_sum > MAX_S) begin
      w_level_nxt = '1;
      w_ovf_set   = 1'b1;
    end else if (w_sum < ZERO_S) begin
      w_level_nxt = '0;
      w_dry_set   = 1'b1;
    end else begin
      w_level_nxt = w_sum[LEVEL_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_level    <= LEVEL_W'(INIT_LEVEL);
      r_overflow <= 1'b0;
      r_dry      <= 1'b0;
    end else if (w_tick) begin
      r_level    <= w_level_nxt;
      r_overflow <= r_overflow | w_ovf_set;
      r_dry      <= r_dry | w_dry_set;
    end else begin
      r_level    <= r_level;
      r_overflow <= r_overflow;
      r_dry      <= r_dry;
    end
  end

  // Region follows the registered level, so sensors lag level by one cycle
  always_comb begin
    w_regiao_nxt = regiao_de(32'(r_level), B_TH, M_TH, A_TH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_regiao <= regiao_de(INIT_LEVEL, B_TH, M_TH, A_TH);
    end else begin
      r_regiao <= w_regiao_nxt;
    end
  end

  assign w_amb = sensores_de(r_regiao);

`ifdef SENSOR_FAULT_EN
  always_comb begin
    w_amb_out = w_amb;
    case (fault_sel)
      FAULT_B: w_amb_out[0] = fault_val;
      FAULT_M: w_amb_out[1] = fault_val;
      FAULT_A: w_amb_out[2] = fault_val;
      default: w_amb_out = w_amb;
    endcase
  end
`else
  assign w_amb_out = w_amb;
`endif

  assign {A, M, B} = w_amb_out;
  assign level     = r_level;
  assign overflow  = r_overflow;
  assign dry       = r_dry;

endmodule

// File: tb/tb_nivel_tanque_sim.sv
// Scoreboard bench for nivel_tanque_sim: five instances with different INIT_LEVEL/TICK_DIV.
module tb_nivel_tanque_sim;

  typedef struct {
    int         due;
    logic [7:0] lvl;
    logic       ovf;
    logic       dry;
  } exp_lvl_t;

  typedef struct {
    int         due;
    logic [2:0] amb;
  } exp_sens_t;

  logic       clk;
  logic       rst;
  logic [4:0] ve;
  logic [4:0] gt;
  logic [4:0] as_i;
  logic [4:0] a_o;
  logic [4:0] m_o;
  logic [4:0] b_o;
  logic [4:0] ovf_o;
  logic [4:0] dry_o;
  logic [7:0] lvl_o [5];
  logic [1:0] fsel;
  logic       fval;

  int checks;
  int errors;

  exp_lvl_t  q_lvl[$];
  exp_sens_t q_sens[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 5; g++) begin : g_dut
    nivel_tanque_sim #(
      .TICK_DIV   ((g == 4) ? 1 : 4),
      .INIT_LEVEL ((g == 1) ? 254 : (g == 2) ? 2 : (g == 3) ? 130 : 0)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .VE        (ve[g]),
      .GT        (gt[g]),
      .AS        (as_i[g]),
`ifdef SENSOR_FAULT_EN
      .fault_sel (fsel),
      .fault_val (fval),
`endif
      .A         (a_o[g]),
      .M         (m_o[g]),
      .B         (b_o[g]),
      .level     (lvl_o[g]),
      .overflow  (ovf_o[g]),
      .dry       (dry_o[g])
    );
  end

  function automatic logic [2:0] amb_of(input int lvl);
    if (lvl >= 224) return 3'b111;
    else if (lvl >= 128) return 3'b011;
    else if (lvl >= 32) return 3'b001;
    else return 3'b000;
  endfunction

  function automatic void model_tick(inout int lvl, inout logic ovf, inout logic dry,
                                     input logic v, input logic g, input logic a);
    int s;
    s = lvl + (v ? 3 : 0) - (g ? 1 : 0) - (a ? 2 : 0);
    if (s > 255) begin
      lvl = 255;
      ovf = 1'b1;
    end else if (s < 0) begin
      lvl = 0;
      dry = 1'b1;
    end else begin
      lvl = s;
    end
  endfunction

  task automatic set_inputs(input int d, input logic v, input logic g, input logic a);
    ve[d]   = v;
    gt[d]   = g;
    as_i[d] = a;
  endtask

  // Leaves the bench at the falling edge right after rst is released
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    int inits [5];
    inits = '{0, 254, 2, 130, 0};
    ve = '0; gt = '0; as_i = '0;
    do_reset();
    @(negedge clk);
    for (int d = 0; d < 5; d++) begin
      checks++;
      if ({lvl_o[d], ovf_o[d], dry_o[d]} !== {inits[d][7:0], 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL reset_state dut%0d got lvl=%0d ovf=%b dry=%b exp lvl=%0d ovf=0 dry=0",
                 d, lvl_o[d], ovf_o[d], dry_o[d], inits[d]);
      end
      checks++;
      if ({a_o[d], m_o[d], b_o[d]} !== amb_of(inits[d])) begin
        errors++;
        $display("FAIL reset_sensors dut%0d got AMB=%b%b%b exp %b",
                 d, a_o[d], m_o[d], b_o[d], amb_of(inits[d]));
      end
    end
  endtask

  task automatic test_fill();
    int m_lvl; logic m_ovf; logic m_dry;
    exp_lvl_t el, gl; exp_sens_t es, gs;
    q_lvl.delete(); q_sens.delete();
    m_lvl = 0; m_ovf = 1'b0; m_dry = 1'b0;
    set_inputs(0, 1'b1, 1'b0, 1'b0);
    do_reset();
    es.due = 1; es.amb = amb_of(m_lvl); q_sens.push_back(es);
    for (int k = 1; k <= 45; k++) begin
      if ((k % 4) == 0) model_tick(m_lvl, m_ovf, m_dry, ve[0], gt[0], as_i[0]);
      el.due = k; el.lvl = m_lvl[7:0]; el.ovf = m_ovf; el.dry = m_dry; q_lvl.push_back(el);
      es.due = k + 1; es.amb = amb_of(m_lvl); q_sens.push_back(es);
      @(negedge clk);
      gl = q_lvl.pop_front();
      checks++;
      if ({lvl_o[0], ovf_o[0], dry_o[0]} !== {gl.lvl, gl.ovf, gl.dry}) begin
        errors++;
        $display("FAIL fill_level cyc=%0d got lvl=%0d ovf=%b dry=%b exp lvl=%0d ovf=%b dry=%b",
                 k, lvl_o[0], ovf_o[0], dry_o[0], gl.lvl, gl.ovf, gl.dry);
      end
      gs = q_sens.pop_front();
      checks++;
      if ({a_o[0], m_o[0], b_o[0]} !== gs.amb) begin
        errors++;
        $display("FAIL fill_sensors cyc=%0d got AMB=%b%b%b exp %b", k, a_o[0], m_o[0], b_o[0], gs.amb);
      end
    end
    checks++;
    if ({lvl_o[0], a_o[0], m_o[0], b_o[0]} !== {8'd33, 3'b001}) begin
      errors++;
      $display("FAIL fill_final got lvl=%0d AMB=%b%b%b exp lvl=33 AMB=001", lvl_o[0], a_o[0], m_o[0], b_o[0]);
    end
    set_inputs(0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_overflow();
    int m_lvl; logic m_ovf; logic m_dry;
    exp_lvl_t el, gl; exp_sens_t es, gs;
    q_lvl.delete(); q_sens.delete();
    m_lvl = 254; m_ovf = 1'b0; m_dry = 1'b0;
    set_inputs(1, 1'b1, 1'b0, 1'b0);
    do_reset();
    es.due = 1; es.amb = amb_of(m_lvl); q_sens.push_back(es);
    for (int k = 1; k <= 16; k++) begin
      if ((k % 4) == 0) model_tick(m_lvl, m_ovf, m_dry, ve[1], gt[1], as_i[1]);
      el.due = k; el.lvl = m_lvl[7:0]; el.ovf = m_ovf; el.dry = m_dry; q_lvl.push_back(el);
      es.due = k + 1; es.amb = amb_of(m_lvl); q_sens.push_back(es);
      @(negedge clk);
      gl = q_lvl.pop_front();
      checks++;
      if ({lvl_o[1], ovf_o[1], dry_o[1]} !== {gl.lvl, gl.ovf, gl.dry}) begin
        errors++;
        $display("FAIL overflow_level cyc=%0d got lvl=%0d ovf=%b dry=%b exp lvl=%0d ovf=%b dry=%b",
                 k, lvl_o[1], ovf_o[1], dry_o[1], gl.lvl, gl.ovf, gl.dry);
      end
      gs = q_sens.pop_front();
      checks++;
      if ({a_o[1], m_o[1], b_o[1]} !== gs.amb) begin
        errors++;
        $display("FAIL overflow_sensors cyc=%0d got AMB=%b%b%b exp %b", k, a_o[1], m_o[1], b_o[1], gs.amb);
      end
      if (k == 4) set_inputs(1, 1'b0, 1'b1, 1'b1);
    end
    checks++;
    if ({lvl_o[1], ovf_o[1]} !== {8'd246, 1'b1}) begin
      errors++;
      $display("FAIL overflow_sticky got lvl=%0d ovf=%b exp lvl=246 ovf=1", lvl_o[1], ovf_o[1]);
    end
    set_inputs(1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_dry();
    int m_lvl; logic m_ovf; logic m_dry;
    exp_lvl_t el, gl; exp_sens_t es, gs;
    q_lvl.delete(); q_sens.delete();
    m_lvl = 2; m_ovf = 1'b0; m_dry = 1'b0;
    set_inputs(2, 1'b0, 1'b1, 1'b1);
    do_reset();
    es.due = 1; es.amb = amb_of(m_lvl); q_sens.push_back(es);
    for (int k = 1; k <= 9; k++) begin
      if ((k % 4) == 0) model_tick(m_lvl, m_ovf, m_dry, ve[2], gt[2], as_i[2]);
      el.due = k; el.lvl = m_lvl[7:0]; el.ovf = m_ovf; el.dry = m_dry; q_lvl.push_back(el);
      es.due = k + 1; es.amb = amb_of(m_lvl); q_sens.push_back(es);
      @(negedge clk);
      gl = q_lvl.pop_front();
      checks++;
      if ({lvl_o[2], ovf_o[2], dry_o[2]} !== {gl.lvl, gl.ovf, gl.dry}) begin
        errors++;
        $display("FAIL dry_level cyc=%0d got lvl=%0d ovf=%b dry=%b exp lvl=%0d ovf=%b dry=%b",
                 k, lvl_o[2], ovf_o[2], dry_o[2], gl.lvl, gl.ovf, gl.dry);
      end
      gs = q_sens.pop_front();
      checks++;
      if ({a_o[2], m_o[2], b_o[2]} !== gs.amb) begin
        errors++;
        $display("FAIL dry_sensors cyc=%0d got AMB=%b%b%b exp %b", k, a_o[2], m_o[2], b_o[2], gs.amb);
      end
      if (k == 4) set_inputs(2, 1'b1, 1'b0, 1'b0);
    end
    checks++;
    if ({lvl_o[2], dry_o[2], ovf_o[2]} !== {8'd3, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL dry_sticky got lvl=%0d dry=%b ovf=%b exp lvl=3 dry=1 ovf=0", lvl_o[2], dry_o[2], ovf_o[2]);
    end
    set_inputs(2, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_net_zero();
    int m_lvl; logic m_ovf; logic m_dry;
    exp_lvl_t el, gl; exp_sens_t es, gs;
    q_lvl.delete(); q_sens.delete();
    m_lvl = 130; m_ovf = 1'b0; m_dry = 1'b0;
    set_inputs(3, 1'b1, 1'b1, 1'b1);
    do_reset();
    es.due = 1; es.amb = amb_of(m_lvl); q_sens.push_back(es);
    for (int k = 1; k <= 41; k++) begin
      if ((k % 4) == 0) model_tick(m_lvl, m_ovf, m_dry, ve[3], gt[3], as_i[3]);
      el.due = k; el.lvl = m_lvl[7:0]; el.ovf = m_ovf; el.dry = m_dry; q_lvl.push_back(el);
      es.due = k + 1; es.amb = amb_of(m_lvl); q_sens.push_back(es);
      @(negedge clk);
      gl = q_lvl.pop_front();
      checks++;
      if ({lvl_o[3], ovf_o[3], dry_o[3]} !== {gl.lvl, gl.ovf, gl.dry}) begin
        errors++;
        $display("FAIL netzero_level cyc=%0d got lvl=%0d ovf=%b dry=%b exp lvl=%0d ovf=%b dry=%b",
                 k, lvl_o[3], ovf_o[3], dry_o[3], gl.lvl, gl.ovf, gl.dry);
      end
      gs = q_sens.pop_front();
      checks++;
      if ({a_o[3], m_o[3], b_o[3]} !== gs.amb) begin
        errors++;
        $display("FAIL netzero_sensors cyc=%0d got AMB=%b%b%b exp %b", k, a_o[3], m_o[3], b_o[3], gs.amb);
      end
    end
    checks++;
    if ({lvl_o[3], a_o[3], m_o[3], b_o[3], ovf_o[3], dry_o[3]} !== {8'd130, 3'b011, 2'b00}) begin
      errors++;
      $display("FAIL netzero_final got lvl=%0d AMB=%b%b%b ovf=%b dry=%b exp lvl=130 AMB=011 ovf=0 dry=0",
               lvl_o[3], a_o[3], m_o[3], b_o[3], ovf_o[3], dry_o[3]);
    end
    set_inputs(3, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_tickdiv1();
    int m_lvl; logic m_ovf; logic m_dry;
    exp_lvl_t el, gl; exp_sens_t es, gs;
    q_lvl.delete(); q_sens.delete();
    m_lvl = 0; m_ovf = 1'b0; m_dry = 1'b0;
    set_inputs(4, 1'b1, 1'b0, 1'b0);
    do_reset();
    es.due = 1; es.amb = amb_of(m_lvl); q_sens.push_back(es);
    for (int k = 1; k <= 88; k++) begin
      model_tick(m_lvl, m_ovf, m_dry, ve[4], gt[4], as_i[4]);
      el.due = k; el.lvl = m_lvl[7:0]; el.ovf = m_ovf; el.dry = m_dry; q_lvl.push_back(el);
      es.due = k + 1; es.amb = amb_of(m_lvl); q_sens.push_back(es);
      @(negedge clk);
      gl = q_lvl.pop_front();
      checks++;
      if ({lvl_o[4], ovf_o[4], dry_o[4]} !== {gl.lvl, gl.ovf, gl.dry}) begin
        errors++;
        $display("FAIL div1_level cyc=%0d got lvl=%0d ovf=%b dry=%b exp lvl=%0d ovf=%b dry=%b",
                 k, lvl_o[4], ovf_o[4], dry_o[4], gl.lvl, gl.ovf, gl.dry);
      end
      gs = q_sens.pop_front();
      checks++;
      if ({a_o[4], m_o[4], b_o[4]} !== gs.amb) begin
        errors++;
        $display("FAIL div1_sensors cyc=%0d got AMB=%b%b%b exp %b", k, a_o[4], m_o[4], b_o[4], gs.amb);
      end
    end
    set_inputs(4, 1'b0, 1'b0, 1'b0);
  endtask

  // Reset landing on a tick edge must win, and the prescaler must restart
  task automatic test_mid_reset();
    set_inputs(0, 1'b1, 1'b0, 1'b0);
    do_reset();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (lvl_o[0] !== 8'd0) begin
      errors++;
      $display("FAIL midreset_override got lvl=%0d exp 0", lvl_o[0]);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (lvl_o[0] !== 8'd0) begin
      errors++;
      $display("FAIL midreset_restart_early got lvl=%0d exp 0", lvl_o[0]);
    end
    @(negedge clk);
    checks++;
    if (lvl_o[0] !== 8'd3) begin
      errors++;
      $display("FAIL midreset_restart_tick got lvl=%0d exp 3", lvl_o[0]);
    end
    set_inputs(0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_pulse();
    set_inputs(0, 1'b0, 1'b0, 1'b0);
    do_reset();
    @(negedge clk);
    ve[0] = 1'b1;
    repeat (2) @(negedge clk);
    ve[0] = 1'b0;
    @(negedge clk);
    checks++;
    if (lvl_o[0] !== 8'd0) begin
      errors++;
      $display("FAIL pulse_ignored got lvl=%0d exp 0", lvl_o[0]);
    end
    repeat (3) @(negedge clk);
    ve[0] = 1'b1;
    @(negedge clk);
    ve[0] = 1'b0;
    checks++;
    if (lvl_o[0] !== 8'd3) begin
      errors++;
      $display("FAIL pulse_on_tick got lvl=%0d exp 3", lvl_o[0]);
    end
  endtask

`ifdef SENSOR_FAULT_EN
  task automatic test_fault();
    set_inputs(0, 1'b0, 1'b0, 1'b0);
    fsel = 2'd0; fval = 1'b0;
    do_reset();
    @(negedge clk);
    fsel = 2'd3; fval = 1'b1;
    #1;
    checks++;
    if ({a_o[0], m_o[0], b_o[0], lvl_o[0]} !== {3'b100, 8'd0}) begin
      errors++;
      $display("FAIL fault_a got AMB=%b%b%b lvl=%0d exp AMB=100 lvl=0", a_o[0], m_o[0], b_o[0], lvl_o[0]);
    end
    fsel = 2'd1;
    #1;
    checks++;
    if ({a_o[0], m_o[0], b_o[0]} !== 3'b001) begin
      errors++;
      $display("FAIL fault_b got AMB=%b%b%b exp 001", a_o[0], m_o[0], b_o[0]);
    end
    fsel = 2'd0;
    #1;
    checks++;
    if ({a_o[0], m_o[0], b_o[0]} !== 3'b000) begin
      errors++;
      $display("FAIL fault_none got AMB=%b%b%b exp 000", a_o[0], m_o[0], b_o[0]);
    end
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    ve     = '0;
    gt     = '0;
    as_i   = '0;
    fsel   = 2'd0;
    fval   = 1'b0;
    test_reset();
    test_fill();
    test_overflow();
    test_dry();
    test_net_zero();
    test_tickdiv1();
    test_mid_reset();
    test_pulse();
`ifdef SENSOR_FAULT_EN
    test_fault();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
